// File: rtl/shift_reg_rx.sv
// Serial-to-parallel receiver: rebuilds LSB-first words framed by an active-low start strobe
// and holds each word under a valid/ack handshake, flagging short frames and overruns.
`timescale 1ns/1ps
module shift_reg_rx #(
   parameter int unsigned TOTAL_BIT_COUNT = 8
) (
   input  logic                       serclk,
   input  logic                       reset,
   input  logic                       frame_start_n,
   input  logic                       s_in,
   input  logic                       data_ack,
   input  logic                       err_clr,
   output logic [TOTAL_BIT_COUNT-1:0] par_data_out,
   output logic                       data_valid,
   output logic                       busy,
   output logic                       overrun,
   output logic                       frame_err
);

   localparam int unsigned N     = TOTAL_BIT_COUNT;
   localparam int unsigned CNT_W = $clog2(TOTAL_BIT_COUNT);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [N-1:0]       shift_q, shift_d;
   logic [N-1:0]       par_q, par_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic               frame_err_q, frame_err_d;

   logic               in_shift;
   logic               last_bit;
   logic               short_frame;
   logic [N-1:0]       word_next;

   assign in_shift    = (state_q == SHIFT);
   assign last_bit    = in_shift && (bit_cnt_q == CNT_W'(N - 1));
   assign short_frame = in_shift && !last_bit && !frame_start_n;
   assign word_next   = {s_in, shift_q[N-1:1]};

   // State register
   always_ff @(posedge serclk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a start strobe on the completing edge keeps us in SHIFT
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!frame_start_n) state_d = SHIFT;
         SHIFT:   if (last_bit && frame_start_n) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q == SHIFT);
   end

   // Datapath and handshake next-state; flag set events take priority over err_clr
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (data_ack && valid_q) valid_d = 1'b0;
      if (err_clr) begin
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end

      if (in_shift) begin
         shift_d   = word_next;
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
         if (last_bit) begin
            bit_cnt_d = '0;
            par_d     = word_next;
            valid_d   = 1'b1;
            if (valid_q && !data_ack) overrun_d = 1'b1;
         end else if (short_frame) begin
            bit_cnt_d   = '0;
            frame_err_d = 1'b1;
         end
      end else begin
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge serclk) begin
      if (reset) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign par_data_out = par_q;
   assign data_valid   = valid_q;
   assign overrun      = overrun_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_shift_reg_rx.sv
// Bench for shift_reg_rx: directed word table, hand-written corner sequences, and random
// traffic checked every cycle against a bit-queue reference model.
`timescale 1ns/1ps
module tb_shift_reg_rx;

   localparam int unsigned N = 8;

   logic         serclk = 1'b0;
   logic         reset = 1'b1;
   logic         frame_start_n = 1'b1;
   logic         s_in = 1'b0;
   logic         data_ack = 1'b0;
   logic         err_clr = 1'b0;
   logic [N-1:0] par_data_out;
   logic         data_valid, busy, overrun, frame_err;

   always #5 serclk = ~serclk;

   shift_reg_rx #(.TOTAL_BIT_COUNT(N)) dut (
      .serclk(serclk), .reset(reset), .frame_start_n(frame_start_n), .s_in(s_in),
      .data_ack(data_ack), .err_clr(err_clr), .par_data_out(par_data_out),
      .data_valid(data_valid), .busy(busy), .overrun(overrun), .frame_err(frame_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: collected bits of the frame in progress plus the visible outputs
   bit           m_active;
   int           m_bits[$];
   logic [N-1:0] m_par;
   bit           m_valid, m_ovr, m_ferr;

   function automatic void check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_edge(input bit fs_n, input bit sin, input bit ack,
                                      input bit clr, input bit rst);
      bit set_ovr = 0, set_ferr = 0, new_valid;
      int w;
      if (rst) begin
         m_active = 0; m_bits.delete(); m_par = '0;
         m_valid = 0; m_ovr = 0; m_ferr = 0;
         return;
      end
      new_valid = m_valid && !ack;
      if (!m_active) begin
         if (!fs_n) begin
            m_active = 1;
            m_bits.delete();
         end
      end else begin
         m_bits.push_back(int'(sin));
         if (m_bits.size() == N) begin
            w = 0;
            for (int i = 0; i < N; i++) w += m_bits[i] * (2 ** i);
            if (m_valid && !ack) set_ovr = 1;
            m_par = N'(w);
            new_valid = 1;
            m_bits.delete();
            m_active = !fs_n;
         end else if (!fs_n) begin
            set_ferr = 1;
            m_bits.delete();
         end
      end
      m_valid = new_valid;
      m_ovr   = set_ovr  ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_ferr  = set_ferr ? 1'b1 : (clr ? 1'b0 : m_ferr);
   endfunction

   // One clock: drive inputs, advance the model on the edge, compare 1ns later
   task automatic step(input bit fs_n, input bit sin, input bit ack, input bit clr, input bit rst);
      frame_start_n = fs_n; s_in = sin; data_ack = ack; err_clr = clr; reset = rst;
      @(posedge serclk);
      model_edge(fs_n, sin, ack, clr, rst);
      #1;
      check("m_par",   par_data_out, m_par);
      check("m_valid", N'(data_valid), N'(m_valid));
      check("m_busy",  N'(busy),       N'(m_active));
      check("m_ovr",   N'(overrun),    N'(m_ovr));
      check("m_ferr",  N'(frame_err),  N'(m_ferr));
   endtask

   task automatic send_bits(input logic [N-1:0] word, input int nbits, input int ack_mode,
                            input bit restart_last);
      for (int b = 0; b < nbits; b++) begin
         step(!(restart_last && b == nbits - 1), word[b],
              (ack_mode == 1) || (ack_mode == 2 && b == nbits - 1), 1'b0, 1'b0);
      end
   endtask

   // ack_mode: 0 never, 1 every bit, 2 only on the completing edge
   typedef struct {
      logic [N-1:0] word;
      int           ack_mode;
      bit           b2b;
      bit           drain;
      bit           clr;
      logic [N-1:0] exp_par;
      bit           exp_valid;
      bit           exp_ovr;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      bit chained;
      vecs[0] = '{8'hA5, 0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
      vecs[1] = '{8'h3C, 1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'hC3, 1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
      vecs[3] = '{8'h01, 0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
      vecs[4] = '{8'h02, 0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1};
      vecs[5] = '{8'h11, 0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
      vecs[6] = '{8'h22, 2, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0};

      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      check("reset_par",   par_data_out, 8'h00);
      check("reset_flags", {4'b0, data_valid, busy, overrun, frame_err}, 8'h00);

      chained = 0;
      foreach (vecs[i]) begin
         if (!chained) begin
            step(0, 1, 0, 0, 0);
            check($sformatf("v%0d_busy_start", i), N'(busy), N'(1));
         end
         send_bits(vecs[i].word, N, vecs[i].ack_mode, vecs[i].b2b);
         check($sformatf("v%0d_par", i),   par_data_out,     vecs[i].exp_par);
         check($sformatf("v%0d_valid", i), N'(data_valid),   N'(vecs[i].exp_valid));
         check($sformatf("v%0d_ovr", i),   N'(overrun),      N'(vecs[i].exp_ovr));
         check($sformatf("v%0d_ferr", i),  N'(frame_err),    N'(0));
         check($sformatf("v%0d_busy", i),  N'(busy),         N'(vecs[i].b2b));
         chained = vecs[i].b2b;
         if (vecs[i].drain || vecs[i].clr) begin
            step(1, 0, vecs[i].drain, vecs[i].clr, 0);
            if (vecs[i].drain) check($sformatf("v%0d_drained", i), N'(data_valid), N'(0));
            if (vecs[i].clr)   check($sformatf("v%0d_ovr_clr", i), N'(overrun), N'(0));
         end
      end

      // Short frame: restart after 4 bits of FF, with err_clr on the same edge (set wins)
      step(0, 0, 0, 0, 0);
      send_bits(8'hFF, 4, 0, 1'b0);
      step(0, 1, 0, 1, 0);
      check("short_ferr",  N'(frame_err),  N'(1));
      check("short_valid", N'(data_valid), N'(0));
      check("short_busy",  N'(busy),       N'(1));
      send_bits(8'h5A, N, 0, 1'b0);
      check("short_par",   par_data_out,   8'h5A);
      check("short_valid2", N'(data_valid), N'(1));
      step(1, 0, 1, 1, 0);
      check("short_ferr_clr", N'(frame_err), N'(0));

      // Reset mid-frame, then a clean frame
      step(0, 0, 0, 0, 0);
      send_bits(8'h81, 3, 0, 1'b0);
      step(1, 1, 0, 0, 1);
      check("rst_mid_par",   par_data_out, 8'h00);
      check("rst_mid_flags", {4'b0, data_valid, busy, overrun, frame_err}, 8'h00);
      step(0, 0, 0, 0, 0);
      send_bits(8'h7E, N, 0, 1'b0);
      check("rst_after_par",   par_data_out,   8'h7E);
      check("rst_after_valid", N'(data_valid), N'(1));

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 11) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
